pic_cascade_ctrl: RTL and testbench

PIC_CASCADE_CTRL -- requirements
Module: pic_cascade_ctrl

---
 rtl/pic_pkg.sv | 16 +
 rtl/pic_cas_timer.sv | 33 +++
 rtl/pic_cascade_ctrl.sv | 128 ++++++++++++
 tb/tb_pic_cascade_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style cascade/INTA sequencing logic.
package pic_pkg;

  localparam int unsigned N_IRQ_DEFAULT = 8;

  localparam logic ROLE_MASTER = 1'b1;
  localparam logic ROLE_SLAVE  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAck1,
    StAck2,
    StAck3
  } pic_state_e;

endpackage

// File: rtl/pic_cas_timer.sv
// Inter-strobe watchdog: flags expiry after TIMEOUT_CYC active cycles without a clear.
module pic_cas_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = active && !clr && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!active || clr || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pic_cascade_ctrl.sv
// Cascade master/slave INTA sequencer for an 8259-style interrupt controller.
// Optional inter-strobe timeout is enabled by defining PIC_CASCADE_TIMEOUT_EN.
module pic_cascade_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
  parameter int unsigned CAS_W       = $clog2(N_IRQ),
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inta_stb,
  input  logic             sngl,
  input  logic             mpm,
  input  logic             buf_mode,
  input  logic             ms_buf,
  input  logic             sp_en_n,
  input  logic [N_IRQ-1:0] icw3,
  input  logic [CAS_W-1:0] irq_id,
  input  logic             irq_vld,
  input  logic [CAS_W-1:0] cas_in,
  output logic [CAS_W-1:0] cas_out,
  output logic             cas_oe,
  output logic             vec_en,
  output logic             byte2_flag,
  output logic             byte3_flag,
  output logic             seq_done,
  output logic             busy
);

  pic_state_e       state_q, state_d;
  logic [CAS_W-1:0] id_q;
  logic             vld_q, master_q, match_q;
  logic             byte2_q, byte2_d, byte3_q, byte3_d, done_q, done_d;
  logic             role, in_seq, cascaded, expired;

  assign role   = buf_mode ? ms_buf : sp_en_n;
  assign in_seq = (state_q != StIdle);

  // Master hands the vector off to a slave only when that IR line has one attached.
  assign cascaded = in_seq && vld_q && (master_q == ROLE_MASTER) && !sngl && icw3[id_q];

  assign cas_oe     = cascaded;
  assign cas_out    = cascaded ? id_q : '0;
  assign vec_en     = in_seq && vld_q && ((master_q == ROLE_SLAVE) ? match_q : !cascaded);
  assign byte2_flag = byte2_q;
  assign byte3_flag = byte3_q;
  assign seq_done   = done_q;
  assign busy       = in_seq;

`ifdef PIC_CASCADE_TIMEOUT_EN
  pic_cas_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (in_seq),
    .clr    (inta_stb),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d = state_q;
    byte2_d = 1'b0;
    byte3_d = 1'b0;
    done_d  = 1'b0;
    if (expired) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inta_stb) state_d = StAck1;
        end
        StAck1: begin
          if (inta_stb) begin
            state_d = StAck2;
            byte2_d = vec_en;
          end
        end
        StAck2: begin
          // 8086 mode ends one cycle after the byte-2 pulse; 8080 mode waits for a third INTA.
          if (mpm) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (inta_stb) begin
            state_d = StAck3;
            byte3_d = vec_en;
          end
        end
        StAck3: begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      id_q     <= '0;
      vld_q    <= 1'b0;
      master_q <= ROLE_SLAVE;
      match_q  <= 1'b0;
      byte2_q  <= 1'b0;
      byte3_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte2_q <= byte2_d;
      byte3_q <= byte3_d;
      done_q  <= done_d;
      if (state_q == StIdle && inta_stb) begin
        id_q     <= irq_vld ? irq_id : '0;
        vld_q    <= irq_vld;
        master_q <= role;
        match_q  <= (cas_in == icw3[CAS_W-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_pic_cascade_ctrl.sv
// Directed, table-driven bench for pic_cascade_ctrl (timeout path when PIC_CASCADE_TIMEOUT_EN).
module tb_pic_cascade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inta_stb = 1'b0;
  logic       sngl = 1'b0, mpm = 1'b0, buf_mode = 1'b0, ms_buf = 1'b0, sp_en_n = 1'b1;
  logic [7:0] icw3 = 8'h00;
  logic [2:0] irq_id = 3'd0, cas_in = 3'd0, cas_out;
  logic       irq_vld = 1'b0;
  logic       cas_oe, vec_en, byte2_flag, byte3_flag, seq_done, busy;

  int errors = 0;
  int checks = 0;
  int b2_cnt, b3_cnt, done_cnt;

  pic_cascade_ctrl #(
    .N_IRQ      (8),
    .CAS_W      (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inta_stb  (inta_stb),
    .sngl      (sngl),
    .mpm       (mpm),
    .buf_mode  (buf_mode),
    .ms_buf    (ms_buf),
    .sp_en_n   (sp_en_n),
    .icw3      (icw3),
    .irq_id    (irq_id),
    .irq_vld   (irq_vld),
    .cas_in    (cas_in),
    .cas_out   (cas_out),
    .cas_oe    (cas_oe),
    .vec_en    (vec_en),
    .byte2_flag(byte2_flag),
    .byte3_flag(byte3_flag),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sngl;
    logic       mpm;
    logic       buf_mode;
    logic       ms_buf;
    logic       sp_en_n;
    logic [7:0] icw3;
    logic [2:0] irq_id;
    logic       irq_vld;
    logic [2:0] cas_in;
    logic [2:0] e_cas_out;
    logic       e_cas_oe;
    logic       e_vec_en;
    int         e_b2;
    int         e_b3;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (byte2_flag) b2_cnt++;
    if (byte3_flag) b3_cnt++;
    if (seq_done) done_cnt++;
  endtask

  task automatic strobe();
    inta_stb = 1'b1;
    tick();
    inta_stb = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    sngl     = v.sngl;
    mpm      = v.mpm;
    buf_mode = v.buf_mode;
    ms_buf   = v.ms_buf;
    sp_en_n  = v.sp_en_n;
    icw3     = v.icw3;
    irq_id   = v.irq_id;
    irq_vld  = v.irq_vld;
    cas_in   = v.cas_in;
    b2_cnt   = 0;
    b3_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    // sngl mpm buf ms sp icw3 id vld cas | cas_out oe vec b2 b3
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 3'd0, 3'd2, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 3'd3, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1, 1, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 3'd1, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hff, 3'd7, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 3'd5, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hff, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 3'd7, 1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 0, 0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 0, 0};

    #3;
    check("reset_outputs", {29'd0, cas_out, cas_oe, vec_en, byte2_flag, byte3_flag, seq_done, busy},
          32'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      strobe();
      check($sformatf("v%0d_cas_out", i), cas_out, vecs[i].e_cas_out);
      check($sformatf("v%0d_cas_oe", i), cas_oe, vecs[i].e_cas_oe);
      check($sformatf("v%0d_vec_en", i), vec_en, vecs[i].e_vec_en);
      check($sformatf("v%0d_busy_ack1", i), busy, 1'b1);
      // Live inputs change mid-sequence; latched values must still govern.
      irq_id  = ~irq_id;
      irq_vld = 1'b0;
      cas_in  = ~cas_in;
      tick();
      tick();
      strobe();
      check($sformatf("v%0d_cas_out_ack2", i), cas_out, vecs[i].e_cas_out);
      check($sformatf("v%0d_vec_en_ack2", i), vec_en, vecs[i].e_vec_en);
      if (!vecs[i].mpm) begin
        tick();
        strobe();
      end
      tick();
      tick();
      tick();
      check($sformatf("v%0d_byte2_cnt", i), b2_cnt, vecs[i].e_b2);
      check($sformatf("v%0d_byte3_cnt", i), b3_cnt, vecs[i].e_b3);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
    end

    // Asynchronous reset while in ACK2, then restart.
    apply(vecs[0]);
    mpm = 1'b0;
    strobe();
    tick();
    strobe();
    check("rst_pre_cas_oe", cas_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {29'd0, cas_out, cas_oe, vec_en, byte2_flag, byte3_flag, seq_done, busy},
          32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst_release_idle", busy, 1'b0);
    strobe();
    check("rst_restart_busy", busy, 1'b1);
    check("rst_restart_cas_oe", cas_oe, 1'b1);
    strobe();
    tick();
    strobe();
    tick();
    tick();
    check("rst_restart_end", busy, 1'b0);

    // Strobe coinciding with seq_done starts a fresh sequence.
    apply(vecs[3]);
    mpm = 1'b1;
    strobe();
    tick();
    strobe();
    check("b2b_byte2", byte2_flag, 1'b1);
    tick();
    check("b2b_done", seq_done, 1'b1);
    inta_stb = 1'b1;
    tick();
    inta_stb = 1'b0;
    check("b2b_restart_busy", busy, 1'b1);
    check("b2b_restart_no_done", seq_done, 1'b0);
    strobe();
    tick();
    tick();
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_byte2_cnt", b2_cnt, 2);

`ifdef PIC_CASCADE_TIMEOUT_EN
    apply(vecs[0]);
    mpm = 1'b0;
    strobe();
    check("to_cas_oe_start", cas_oe, 1'b1);
    repeat (7) tick();
    check("to_busy_before", busy, 1'b1);
    check("to_no_done_before", seq_done, 1'b0);
    tick();
    check("to_idle", busy, 1'b0);
    check("to_done", seq_done, 1'b1);
    check("to_cas_oe_drop", cas_oe, 1'b0);
`else
    apply(vecs[0]);
    strobe();
    repeat (20) tick();
    check("nto_still_busy", busy, 1'b1);
    check("nto_cas_oe_held", cas_oe, 1'b1);
    check("nto_no_done", done_cnt, 0);
    strobe();
    tick();
    tick();
    check("nto_end", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
